// File: rtl/data_table_delete_chain.sv
// Delete engine for the chained hash table: walks one bucket chain, unlinks the first
// entry whose key matches, zeroes it and returns its address to the free list.
module data_table_delete_chain #(
    parameter int unsigned KEY_WIDTH     = 32,
    parameter int unsigned VALUE_WIDTH   = 32,
    parameter int unsigned A_WIDTH       = 8,
    parameter int unsigned BUCKET_WIDTH  = 8,
    parameter int unsigned TAG_WIDTH     = 8,
    parameter int unsigned RAM_LATENCY   = 2,
    parameter int unsigned MAX_CHAIN_LEN = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic [KEY_WIDTH-1:0]    task_key_i,
    input  logic [BUCKET_WIDTH-1:0] task_bucket_i,
    input  logic [A_WIDTH-1:0]      task_head_ptr_i,
    input  logic                    task_head_ptr_val_i,
    input  logic [TAG_WIDTH-1:0]    task_tag_i,
    input  logic                    task_valid_i,
    output logic                    task_ready_o,
    output logic [A_WIDTH-1:0]      rd_addr_o,
    output logic                    rd_en_o,
    input  logic [KEY_WIDTH-1:0]    rd_key_i,
    input  logic [VALUE_WIDTH-1:0]  rd_value_i,
    input  logic [A_WIDTH-1:0]      rd_next_ptr_i,
    input  logic                    rd_next_ptr_val_i,
    output logic [A_WIDTH-1:0]      wr_addr_o,
    output logic                    wr_en_o,
    output logic [KEY_WIDTH-1:0]    wr_key_o,
    output logic [VALUE_WIDTH-1:0]  wr_value_o,
    output logic [A_WIDTH-1:0]      wr_next_ptr_o,
    output logic                    wr_next_ptr_val_o,
    output logic [A_WIDTH-1:0]      add_empty_ptr_o,
    output logic                    add_empty_ptr_en_o,
    output logic [BUCKET_WIDTH-1:0] head_wr_addr_o,
    output logic [A_WIDTH-1:0]      head_wr_ptr_o,
    output logic                    head_wr_ptr_val_o,
    output logic                    head_wr_en_o,
    output logic [TAG_WIDTH-1:0]    res_tag_o,
    output logic [VALUE_WIDTH-1:0]  res_value_o,
    output logic [1:0]              res_code_o,
    output logic                    res_valid_o,
    input  logic                    res_ready_i
);

    localparam int unsigned HOP_W = $clog2(MAX_CHAIN_LEN + 1);
    localparam logic [HOP_W-1:0] HOP_MAX = HOP_W'(MAX_CHAIN_LEN);

    typedef enum logic [2:0] {
        IDLE, RD_ISSUE, RD_WAIT, UNLINK_HEAD, UNLINK_PREV, CLEAR, RESULT
    } state_e;

    typedef enum logic [1:0] {
        RES_SUCCESS     = 2'd0,
        RES_NO_ENTRY    = 2'd1,
        RES_CHAIN_LIMIT = 2'd2
    } res_code_e;

    state_e                  state_q, state_d;
    logic [KEY_WIDTH-1:0]    key_q;
    logic [BUCKET_WIDTH-1:0] bucket_q;
    logic [TAG_WIDTH-1:0]    tag_q;
    logic [A_WIDTH-1:0]      cur_addr_q, prev_addr_q;
    logic [KEY_WIDTH-1:0]    prev_key_q;
    logic [VALUE_WIDTH-1:0]  prev_value_q, cur_value_q;
    logic [A_WIDTH-1:0]      cur_next_q;
    logic                    cur_next_val_q;
    logic                    first_q;
    logic [HOP_W-1:0]        hops_q;
    logic [RAM_LATENCY-1:0]  vld_sr_q;
    logic [VALUE_WIDTH-1:0]  res_value_q;
    res_code_e               res_code_q;

    logic data_cyc, key_hit, chain_stop;

    assign data_cyc   = (state_q == RD_WAIT) && vld_sr_q[RAM_LATENCY-1];
    assign key_hit    = (rd_key_i == key_q);
    assign chain_stop = (rd_next_ptr_i == cur_addr_q) || (hops_q == HOP_MAX);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // A match wins over the end-of-chain, self-loop and hop-limit exits.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:        if (task_valid_i) state_d = task_head_ptr_val_i ? RD_ISSUE : RESULT;
            RD_ISSUE:    state_d = RD_WAIT;
            RD_WAIT: begin
                if (data_cyc) begin
                    if (key_hit)                               state_d = first_q ? UNLINK_HEAD : UNLINK_PREV;
                    else if (!rd_next_ptr_val_i || chain_stop) state_d = RESULT;
                    else                                       state_d = RD_ISSUE;
                end
            end
            UNLINK_HEAD: state_d = CLEAR;
            UNLINK_PREV: state_d = CLEAR;
            CLEAR:       state_d = RESULT;
            RESULT:      if (res_ready_i) state_d = IDLE;
            default:     state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_sr_q <= '0;
        end else begin
            vld_sr_q[0] <= (state_q == RD_ISSUE);
            for (int unsigned i = 1; i < RAM_LATENCY; i++) vld_sr_q[i] <= vld_sr_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            key_q          <= '0;
            bucket_q       <= '0;
            tag_q          <= '0;
            cur_addr_q     <= '0;
            prev_addr_q    <= '0;
            prev_key_q     <= '0;
            prev_value_q   <= '0;
            cur_value_q    <= '0;
            cur_next_q     <= '0;
            cur_next_val_q <= 1'b0;
            first_q        <= 1'b0;
            hops_q         <= '0;
            res_value_q    <= '0;
            res_code_q     <= RES_SUCCESS;
        end else begin
            case (state_q)
                IDLE: begin
                    if (task_valid_i) begin
                        key_q       <= task_key_i;
                        bucket_q    <= task_bucket_i;
                        tag_q       <= task_tag_i;
                        cur_addr_q  <= task_head_ptr_i;
                        first_q     <= 1'b1;
                        hops_q      <= '0;
                        res_value_q <= '0;
                        res_code_q  <= task_head_ptr_val_i ? RES_SUCCESS : RES_NO_ENTRY;
                    end
                end
                RD_ISSUE: begin
                    if (hops_q != HOP_MAX) hops_q <= hops_q + 1'b1;
                end
                RD_WAIT: begin
                    if (data_cyc) begin
                        cur_value_q    <= rd_value_i;
                        cur_next_q     <= rd_next_ptr_i;
                        cur_next_val_q <= rd_next_ptr_val_i;
                        if (!key_hit) begin
                            if (!rd_next_ptr_val_i) begin
                                res_code_q <= RES_NO_ENTRY;
                            end else if (chain_stop) begin
                                res_code_q <= RES_CHAIN_LIMIT;
                            end else begin
                                prev_addr_q  <= cur_addr_q;
                                prev_key_q   <= rd_key_i;
                                prev_value_q <= rd_value_i;
                                cur_addr_q   <= rd_next_ptr_i;
                                first_q      <= 1'b0;
                            end
                        end
                    end
                end
                CLEAR: begin
                    res_value_q <= cur_value_q;
                    res_code_q  <= RES_SUCCESS;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_en_o            = 1'b0;
        rd_addr_o          = '0;
        wr_en_o            = 1'b0;
        wr_addr_o          = '0;
        wr_key_o           = '0;
        wr_value_o         = '0;
        wr_next_ptr_o      = '0;
        wr_next_ptr_val_o  = 1'b0;
        add_empty_ptr_en_o = 1'b0;
        add_empty_ptr_o    = '0;
        head_wr_en_o       = 1'b0;
        head_wr_addr_o     = '0;
        head_wr_ptr_o      = '0;
        head_wr_ptr_val_o  = 1'b0;
        case (state_q)
            RD_ISSUE: begin
                rd_en_o   = 1'b1;
                rd_addr_o = cur_addr_q;
            end
            UNLINK_HEAD: begin
                head_wr_en_o      = 1'b1;
                head_wr_addr_o    = bucket_q;
                head_wr_ptr_o     = cur_next_q;
                head_wr_ptr_val_o = cur_next_val_q;
            end
            UNLINK_PREV: begin
                wr_en_o           = 1'b1;
                wr_addr_o         = prev_addr_q;
                wr_key_o          = prev_key_q;
                wr_value_o        = prev_value_q;
                wr_next_ptr_o     = cur_next_q;
                wr_next_ptr_val_o = cur_next_val_q;
            end
            CLEAR: begin
                wr_en_o            = 1'b1;
                wr_addr_o          = cur_addr_q;
                add_empty_ptr_en_o = 1'b1;
                add_empty_ptr_o    = cur_addr_q;
            end
            default: ;
        endcase
    end

    assign task_ready_o = (state_q == IDLE);
    assign res_valid_o  = (state_q == RESULT);
    assign res_tag_o    = tag_q;
    assign res_value_o  = res_value_q;
    assign res_code_o   = res_code_q;

endmodule

// File: doc/data_table_delete_chain.md
# data_table_delete_chain

Parametrised delete engine for the chained hash table data RAM. It accepts one delete task per bucket (key, head pointer), walks the chain and unlinks the first entry whose key matches. Unlinking means patching either the head table or the predecessor's next pointer, then zeroing the entry and returning its address to the empty-pointer storage. It sits between the per-command dispatcher and the data RAM / head table / empty-pointer storage, replacing the fixed-width struct-based delete block. New capabilities: fully parametric widths, latched read data, the deleted value returned in the result, and a chain-length / self-loop guard.

## Interface
Parameters:
- KEY_WIDTH, 32, key width
- VALUE_WIDTH, 32, value width
- A_WIDTH, 8, data RAM address width
- BUCKET_WIDTH, 8, head table address width
- TAG_WIDTH, 8, opaque command tag, passed task → result
- RAM_LATENCY, 2, read latency in cycles, 1..8
- MAX_CHAIN_LEN, 16, maximum reads per task, ≥1

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock
- rst_n_i  in  1  async active-low reset
- task_key_i / task_bucket_i / task_head_ptr_i / task_head_ptr_val_i / task_tag_i  in  KEY_WIDTH/BUCKET_WIDTH/A_WIDTH/1/TAG_WIDTH  task fields
- task_valid_i  in  1; task_ready_o  out  1  task handshake
- rd_addr_o  out  A_WIDTH; rd_en_o  out  1  RAM read
- rd_key_i / rd_value_i / rd_next_ptr_i / rd_next_ptr_val_i  in  KEY_WIDTH/VALUE_WIDTH/A_WIDTH/1  RAM read data, valid RAM_LATENCY cycles after rd_en_o
- wr_addr_o  out  A_WIDTH; wr_en_o  out  1; wr_key_o / wr_value_o / wr_next_ptr_o / wr_next_ptr_val_o  out  RAM write
- add_empty_ptr_o  out  A_WIDTH; add_empty_ptr_en_o  out  1  free-list push
- head_wr_addr_o  out  BUCKET_WIDTH; head_wr_ptr_o  out  A_WIDTH; head_wr_ptr_val_o  out  1; head_wr_en_o  out  1  head table write
- res_tag_o  out  TAG_WIDTH; res_value_o  out  VALUE_WIDTH; res_code_o  out  2 (0 SUCCESS, 1 NO_ENTRY, 2 CHAIN_LIMIT)
- res_valid_o  out  1; res_ready_i  in  1  result handshake

## Operation
- States: IDLE, RD_ISSUE, RD_WAIT, UNLINK_HEAD, UNLINK_PREV, CLEAR, RESULT.
- IDLE: task_ready_o=1. On accept, latch all task fields and clear the hop counter.
  - head_ptr_val=0 → RESULT with NO_ENTRY.
  - Otherwise cur_addr=head_ptr, first=1 → RD_ISSUE.
- RD_ISSUE: one-cycle rd_en_o pulse at cur_addr; hop counter +1 → RD_WAIT.
- RD_WAIT: an internal RAM_LATENCY-deep valid shift register marks the data cycle. In that cycle, latch rd_* into cur_data, then:
  - key match and first → UNLINK_HEAD
  - key match and not first → UNLINK_PREV
  - no match and rd_next_ptr_val_i=0 → RESULT with NO_ENTRY
  - no match and (rd_next_ptr_i==cur_addr or hop count==MAX_CHAIN_LEN) → RESULT with CHAIN_LIMIT, no writes
  - otherwise: prev_addr=cur_addr, prev_data=cur_data, cur_addr=rd_next_ptr_i, first=0 → RD_ISSUE
- UNLINK_HEAD (1 cycle): head_wr_en_o=1, addr=bucket, ptr/ptr_val = cur_data.next_ptr/next_ptr_val → CLEAR.
- UNLINK_PREV (1 cycle): wr_en_o=1 at prev_addr with prev_data key/value, next_ptr/next_ptr_val = cur_data.next_ptr/next_ptr_val. A tail match therefore writes next_ptr_val=0 → CLEAR.
- CLEAR (1 cycle): wr_en_o=1 at cur_addr with all data zero; add_empty_ptr_en_o=1 with add_empty_ptr_o=cur_addr. res_value captures cur_data.value; code=SUCCESS → RESULT.
- RESULT: res_valid_o=1 with res_tag_o = latched tag. res_value_o=0 unless SUCCESS. Leave on res_valid_o & res_ready_i → IDLE.
- A match always takes priority over the limit and loop checks.

## Timing
- Reset: every output 0 except task_ready_o=1 (IDLE). All internal registers cleared.
- Reset asserted mid-task: the task is abandoned immediately. No further write, head, free-list or result strobe.
- Accept at cycle T:
  - first rd_en_o at T+1
  - data cycle at T+1+RAM_LATENCY
  - each further hop adds RAM_LATENCY+1 cycles
- Head match: head_wr_en_o at T+2+L, CLEAR at T+3+L, res_valid_o from T+4+L (L=RAM_LATENCY).
- Middle/tail match on hop n (n≥2): UNLINK_PREV at T+n(L+1)+1, then CLEAR, then RESULT.
- Strobe rules:
  - rd_en_o, wr_en_o, head_wr_en_o and add_empty_ptr_en_o are single-cycle pulses, at most one of each per state entry.
  - wr_en_o is never asserted in the same cycle as rd_en_o.
- Result outputs are registered and stay stable while res_valid_o=1 and res_ready_i=0.
- task_ready_o=0 from the accept cycle +1 until the cycle after the result handshake, i.e. one task in flight.
- The hop counter saturates. Reads never exceed MAX_CHAIN_LEN per task.

## Test plan
- No head: head_ptr_val=0, tag=0x11 → no rd_en_o; res_code=1, res_value=0, res_valid at T+1.
- Head match, L=2: head=5, entry 5 = {key=0xA, value=0x77, next=9 valid} → head_wr {bucket, 9, 1} at T+4; zero write to 5 and free-list 5 at T+5; result SUCCESS, value=0x77.
- Tail match: chain 3→7, key in 7 → write addr 3 with next_ptr_val=0, keeping 3's key/value; zero 7; free-list push 7; SUCCESS.
- Middle match: chain 3→7→2, key in 7 → write addr 3 with next_ptr=2, valid=1; clear 7; no head write.
- Chain limit: MAX_CHAIN_LEN=4, chain of 6 entries without the key → exactly 4 rd_en_o pulses, CHAIN_LIMIT, no writes. Self-loop at entry 4 (next_ptr=4) → CHAIN_LIMIT after 1 read.
- Back-pressure and reset: hold res_ready_i=0 for 10 cycles → outputs stable, task_ready_o=0. Deassert rst_n_i while in RD_WAIT → all strobes 0 and task_ready_o=1 after release.
